palette_lut: RTL and testbench

Programmable, registered colour palette for the tile renderer. It replaces the fixed value-to-colour table: tile value in, 24-bit pixel colour out one cycle later. The palette is rewritable at runtime through a write port, and self-initialises after reset. It adds a blink-highlight mode for one selected tile value. It sits between the board-state reader and the VGA pixel mux.

---
 rtl/palette_lut.sv | 136 +++++++++++++
 tb/tb_palette_lut.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/palette_lut.sv
// Programmable registered colour palette: tile value in, colour out one cycle later.
// Self-fills with FILL_COLOR after reset and can blink-invert one selected tile value.
//
// state   | meaning
// --------|-------------------------------------------------------------
// ST_INIT | writing FILL_COLOR to entry init_cnt, lookups return OOR_COLOR
// ST_RUN  | normal lookups and user writes; left only by reset
module palette_lut #(
  parameter int               N_ENTRIES    = 13,
  parameter int               IDX_W        = 5,
  parameter int               COLOR_W      = 24,
  parameter logic [COLOR_W-1:0] FILL_COLOR = 24'h1C1C1C,
  parameter logic [COLOR_W-1:0] OOR_COLOR  = 24'h0C0C0C,
  parameter int               BLINK_PERIOD = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               rd_valid,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               hl_en,
  input  logic [IDX_W-1:0]   hl_idx,
  output logic               pix_valid,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               init_busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int BLINK_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_ENTRIES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_PERIOD - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     init_cnt_q, init_cnt_d;
  logic [COLOR_W-1:0]   palette_q [N_ENTRIES];
  logic [COLOR_W-1:0]   palette_d [N_ENTRIES];
  logic                 pix_valid_q, pix_valid_d;
  logic [COLOR_W-1:0]   pixel_color_q, pixel_color_d;
  logic [BLINK_W-1:0]   blink_tmr_q, blink_tmr_d;
  logic                 blink_phase_q, blink_phase_d;

  logic                 rd_in_range;
  logic [COLOR_W-1:0]   rd_entry;
  logic [COLOR_W-1:0]   rd_base;
  logic [COLOR_W-1:0]   rd_result;
  logic                 wr_hit;
  logic                 hl_hit;

  // Palette fill during init, user writes during run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    palette_d  = palette_q;
    case (state_q)
      ST_INIT: begin
        for (int i = 0; i < N_ENTRIES; i++) begin
          if (init_cnt_q == IDX_W'(i)) palette_d[i] = FILL_COLOR;
        end
        if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
        else                        init_cnt_d = init_cnt_q + IDX_W'(1);
      end
      ST_RUN: begin
        if (wr_en) begin
          for (int i = 0; i < N_ENTRIES; i++) begin
            if (wr_idx == IDX_W'(i)) palette_d[i] = wr_color;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Index decode doubles as the range check, so no compare against N_ENTRIES is needed.
  always_comb begin
    rd_in_range = 1'b0;
    rd_entry    = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_in_range = 1'b1;
        rd_entry    = palette_q[i];
      end
    end
  end

  always_comb begin
    wr_hit    = (state_q == ST_RUN) && wr_en && (wr_idx == rd_idx);
    rd_base   = wr_hit ? wr_color : rd_entry;
    hl_hit    = hl_en && blink_phase_q && (rd_idx == hl_idx);
    rd_result = OOR_COLOR;
    if ((state_q == ST_RUN) && rd_in_range) begin
      rd_result = hl_hit ? ~rd_base : rd_base;
    end
    pix_valid_d   = rd_valid;
    pixel_color_d = rd_valid ? rd_result : pixel_color_q;
  end

  always_comb begin
    blink_tmr_d   = blink_tmr_q - BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_tmr_q == '0) begin
      blink_tmr_d   = BLINK_LOAD;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      pixel_color_q <= '0;
      blink_tmr_q   <= BLINK_LOAD;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      pix_valid_q   <= pix_valid_d;
      pixel_color_q <= pixel_color_d;
      blink_tmr_q   <= blink_tmr_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Contents are rebuilt by the init sweep, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    palette_q <= palette_d;
  end

  assign pix_valid   = pix_valid_q;
  assign pixel_color = pixel_color_q;
  assign init_busy   = (state_q == ST_INIT);

endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut: vector table, hand sequences for init/blink/reset,
// and random traffic checked every cycle against a cycle-count based model.
module tb_palette_lut;
  localparam int N  = 13;
  localparam int IW = 5;
  localparam int CW = 24;
  localparam int P  = 4;
  localparam logic [CW-1:0] FILL = 24'h1C1C1C;
  localparam logic [CW-1:0] OOR  = 24'h0C0C0C;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [CW-1:0] wr_color = '0;
  logic          rd_valid = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic          hl_en = 1'b0;
  logic [IW-1:0] hl_idx = '0;
  logic          pix_valid;
  logic [CW-1:0] pixel_color;
  logic          init_busy;

  palette_lut #(
    .N_ENTRIES(N), .IDX_W(IW), .COLOR_W(CW),
    .FILL_COLOR(FILL), .OOR_COLOR(OOR), .BLINK_PERIOD(P)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_color(wr_color),
    .rd_valid(rd_valid), .rd_idx(rd_idx),
    .hl_en(hl_en), .hl_idx(hl_idx),
    .pix_valid(pix_valid), .pixel_color(pixel_color), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: t counts edges since reset release; init and blink phase follow from t.
  logic [CW-1:0] pal [N];
  int            t = 0;
  logic          m_valid = 1'b0;
  logic [CW-1:0] m_color = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0d", name, act, exp, t);
    end
  endtask

  task automatic step();
    logic [CW-1:0] res;
    if (!rst) begin
      t       = 0;
      m_valid = 1'b0;
      m_color = '0;
    end else begin
      if (rd_valid) begin
        if (t < N || int'(rd_idx) >= N) begin
          res = OOR;
        end else begin
          res = (wr_en && wr_idx == rd_idx) ? wr_color : pal[int'(rd_idx)];
          if (hl_en && ((t / P) % 2 == 1) && rd_idx == hl_idx) res = ~res;
        end
        m_color = res;
      end
      m_valid = rd_valid;
      if (t < N) pal[t] = FILL;
      else if (wr_en && int'(wr_idx) < N) pal[int'(wr_idx)] = wr_color;
      t++;
    end
    @(posedge clk);
    #1;
    chk("pix_valid", 32'(pix_valid), 32'(m_valid));
    chk("pixel_color", 32'(pixel_color), 32'(m_color));
    chk("init_busy", 32'(init_busy), 32'(t < N));
  endtask

  typedef struct {
    logic          we;
    logic [IW-1:0] wi;
    logic [CW-1:0] wc;
    logic          rv;
    logic [IW-1:0] ri;
    logic          ev;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vecs [8];
  int   n;

  initial begin
    vecs[0] = '{1'b1, 5'd11, 24'hCCFFCC, 1'b0, 5'd0,  1'b0, 24'h0};
    vecs[1] = '{1'b0, 5'd0,  24'h0,      1'b1, 5'd11, 1'b1, 24'hCCFFCC};
    vecs[2] = '{1'b0, 5'd0,  24'h0,      1'b1, 5'd12, 1'b1, 24'h1C1C1C};
    vecs[3] = '{1'b0, 5'd0,  24'h0,      1'b1, 5'd31, 1'b1, 24'h0C0C0C};
    vecs[4] = '{1'b0, 5'd0,  24'h0,      1'b0, 5'd0,  1'b0, 24'h0};
    vecs[5] = '{1'b1, 5'd4,  24'hFFCCCC, 1'b1, 5'd4,  1'b1, 24'hFFCCCC};
    vecs[6] = '{1'b1, 5'd20, 24'h123456, 1'b0, 5'd0,  1'b0, 24'h0};
    vecs[7] = '{1'b0, 5'd0,  24'h0,      1'b1, 5'd20, 1'b1, 24'h0C0C0C};
    for (int i = 0; i < N; i++) pal[i] = '0;

    // Reset then init sweep with a read of idx 2 every cycle
    rst = 1'b0; rd_valid = 1'b1; rd_idx = 5'd2;
    repeat (3) step();
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    rst = 1'b1;
    n = 0;
    while (init_busy && n < 100) begin
      step();
      n++;
      chk("init_oor", 32'(pixel_color), 32'(OOR));
    end
    chk("init_len", n, 32'd13);
    step();
    chk("init_fill", 32'(pixel_color), 32'(FILL));

    // Vector table: program, read, bypass, ignored write
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].we; wr_idx = vecs[i].wi; wr_color = vecs[i].wc;
      rd_valid = vecs[i].rv; rd_idx = vecs[i].ri;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_color", i), 32'(pixel_color), 32'(vecs[i].ec));
    end
    wr_en = 1'b0;

    // Highlight blink on idx 3
    wr_en = 1'b1; wr_idx = 5'd3; wr_color = 24'hFFCC99; rd_valid = 1'b0;
    step();
    wr_en = 1'b0; hl_en = 1'b1; hl_idx = 5'd3; rd_valid = 1'b1; rd_idx = 5'd3;
    n = 0;
    while ((t % 8) != 0 && n < 8) begin step(); n++; end
    for (int k = 0; k < 16; k++) begin
      step();
      chk("hl_pattern", 32'(pixel_color), ((k / 4) % 2 == 1) ? 32'h003366 : 32'hFFCC99);
    end
    rd_idx = 5'd5;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("hl_other_idx", 32'(pixel_color), 32'(FILL));
    end
    rd_idx = 5'd3; hl_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("hl_disabled", 32'(pixel_color), 32'hFFCC99);
    end

    // Reset mid-run loses user writes and restarts the blink phase
    wr_en = 1'b1; wr_idx = 5'd1; wr_color = 24'hFFFFCC; rd_valid = 1'b0;
    step();
    wr_en = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    n = 0;
    while (init_busy && n < 100) begin step(); n++; end
    chk("reinit_len", n, 32'd13);
    rd_valid = 1'b1; rd_idx = 5'd1; hl_idx = 5'd1; hl_en = 1'b0;
    step();
    chk("reinit_idx1", 32'(pixel_color), 32'h1C1C1C);
    hl_en = 1'b1;
    step();
    chk("phase_t14", 32'(pixel_color), 32'hE3E3E3);
    step();
    chk("phase_t15", 32'(pixel_color), 32'hE3E3E3);
    step();
    chk("phase_t16", 32'(pixel_color), 32'h1C1C1C);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 149) != 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_idx   = IW'($urandom_range(0, 17));
      wr_color = CW'($urandom);
      rd_valid = ($urandom_range(0, 3) != 0);
      rd_idx   = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(0, 13));
      if ($urandom_range(0, 3) == 0) rd_idx = wr_idx;
      if ($urandom_range(0, 19) == 0) hl_en = ~hl_en;
      if ($urandom_range(0, 19) == 0) hl_idx = IW'($urandom_range(0, 14));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
